vga_sync_gen: RTL

- Consumes the 25 MHz pixel clock produced by the clock divider, supplied on clk_in.
- Generates 640x480@60 VGA horizontal/vertical sync and a visible-area flag.
- Generates read addresses for the 320x240 camera frame buffer, upscaled 2x in each axis.
- Address stage runs one cycle ahead of the sync/pixel stage, so single-cycle-latency BRAM read data aligns with video_on.

---
 rtl/vga_sync_gen.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator with a 2x-upscaled frame buffer read port.
// The address stage runs one cycle ahead of the sync/pixel stage so BRAM read data lines up with video_on.
module vga_sync_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   FB_WIDTH  = 320,
  parameter int   FB_ADDR_W = 17
) (
  input  logic                 clk_in,
  input  logic                 reset,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 video_on,
  output logic [9:0]           pixel_x,
  output logic [9:0]           pixel_y,
  output logic                 line_start,
  output logic                 frame_start,
  output logic                 fb_rd_en,
  output logic [FB_ADDR_W-1:0] fb_addr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] L_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0] L_V_ACTIVE = 10'(V_ACTIVE);
  localparam logic [9:0] L_H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] L_V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] L_HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] L_HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] L_VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] L_VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Constant multiply by FB_WIDTH unrolled into a sum of shifted copies of the row index.
  function automatic logic [FB_ADDR_W-1:0] mulFbWidth(input logic [8:0] row);
    logic [FB_ADDR_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < FB_ADDR_W; b++) begin
      if (((FB_WIDTH >> b) & 1) != 0) acc = acc + (FB_ADDR_W'(row) << b);
    end
    return acc;
  endfunction

  logic [9:0]           r_hCnt;
  logic [9:0]           r_vCnt;
  logic [9:0]           r_hDly;
  logic [9:0]           r_vDly;
  logic                 r_rdEn;
  logic [FB_ADDR_W-1:0] r_addr;
  logic                 r_videoOn;
  logic                 r_hsync;
  logic                 r_vsync;
  logic [9:0]           r_pixelX;
  logic [9:0]           r_pixelY;
  logic                 r_lineStart;
  logic                 r_frameStart;

  logic                 w_visible;
  logic [FB_ADDR_W-1:0] w_rowBase;
  logic [FB_ADDR_W-1:0] w_addr;
  logic                 w_inHsync;
  logic                 w_inVsync;

  assign w_visible = (r_hCnt < L_H_ACTIVE) && (r_vCnt < L_V_ACTIVE);
  assign w_rowBase = mulFbWidth(r_vCnt[9:1]);
  assign w_addr    = w_rowBase + FB_ADDR_W'(r_hCnt[9:1]);
  assign w_inHsync = (r_hDly >= L_HS_FIRST) && (r_hDly <= L_HS_LAST);
  assign w_inVsync = (r_vDly >= L_VS_FIRST) && (r_vDly <= L_VS_LAST);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (r_hCnt == L_H_LAST) begin
      r_hCnt <= '0;
      r_vCnt <= (r_vCnt == L_V_LAST) ? 10'd0 : r_vCnt + 10'd1;
    end else begin
      r_hCnt <= r_hCnt + 10'd1;
    end
  end

  // Stage 1: frame buffer address plus a delayed copy of the counters for stage 2.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_rdEn <= 1'b0;
      r_addr <= '0;
      r_hDly <= '0;
      r_vDly <= '0;
    end else begin
      r_rdEn <= w_visible;
      if (w_visible) r_addr <= w_addr;
      r_hDly <= r_hCnt;
      r_vDly <= r_vCnt;
    end
  end

  // Stage 2: pulses are gated by the delayed visible flag so the cleared delay registers never fake a pixel (0,0).
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_videoOn    <= 1'b0;
      r_hsync      <= ~SYNC_POL;
      r_vsync      <= ~SYNC_POL;
      r_pixelX     <= '0;
      r_pixelY     <= '0;
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_videoOn    <= r_rdEn;
      r_hsync      <= w_inHsync ? SYNC_POL : ~SYNC_POL;
      r_vsync      <= w_inVsync ? SYNC_POL : ~SYNC_POL;
      r_pixelX     <= r_rdEn ? r_hDly : 10'd0;
      r_pixelY     <= r_rdEn ? r_vDly : 10'd0;
      r_lineStart  <= r_rdEn && (r_hDly == 10'd0);
      r_frameStart <= r_rdEn && (r_hDly == 10'd0) && (r_vDly == 10'd0);
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_videoOn;
  assign pixel_x     = r_pixelX;
  assign pixel_y     = r_pixelY;
  assign line_start  = r_lineStart;
  assign frame_start = r_frameStart;
  assign fb_rd_en    = r_rdEn;
  assign fb_addr     = r_addr;

endmodule
